ostream_pkt_arbiter: RTL and testbench

Parametrised multi-channel output-stream block that generalises the single ostream channel to NUM_CH packet sources, for example the SOUT and PSOUT buffers.
- Each channel is buffered in its own FIFO, which reports full and empty status.
- Channels are merged onto one ostream valid/ready bus with packet-atomic round-robin arbitration, first/last framing and a channel tag.
- Sits between the compute-side output buffers and the ostream interface.

---
 rtl/ostream_pkt_arbiter.sv | 150 +++++++++++++++
 tb/tb_ostream_pkt_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ostream_pkt_arbiter.sv
// rtl/ostream_pkt_arbiter.sv - per-channel packet FIFOs merged onto one ostream bus by packet-atomic round-robin
module ostream_pkt_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         ostream_clk,
    input  logic                         ostream_rst,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_first,
    input  logic [NUM_CH-1:0]            ch_last,
    output logic [NUM_CH-1:0]            ch_ready,
    output logic                         ostream_valid,
    output logic [DATA_WIDTH-1:0]        ostream_data,
    output logic                         ostream_first,
    output logic                         ostream_last,
    output logic [CH_W-1:0]              ostream_ch_id,
    input  logic                         ostream_ready,
    output logic [NUM_CH-1:0]            buff_full,
    output logic [NUM_CH-1:0]            buff_empty,
    output logic                         proto_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state, state_next;
    logic [CH_W-1:0]   ptr, ptr_next, next_ch;
    logic [NUM_CH-1:0] push, pop, err_hit;
    logic [EW-1:0]     head [NUM_CH];
    logic [EW-1:0]     head_sel;
    logic              any_req, load;

    assign ch_ready = ostream_rst ? '0 : ~buff_full;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Entry layout: {first, last, data}
        logic [EW-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr, rd_ptr;
        logic [CW-1:0] count, count_next;
        logic          in_pkt, full_q, empty_q;

        assign push[i]       = ch_valid[i] && ch_ready[i];
        assign head[i]       = mem[rd_ptr];
        assign count_next    = count + CW'(push[i]) - CW'(pop[i]);
        // first must be 1 exactly when no packet is open on this channel
        assign err_hit[i]    = push[i] && (ch_first[i] == in_pkt);
        assign buff_full[i]  = full_q;
        assign buff_empty[i] = empty_q;

        always_ff @(posedge ostream_clk) begin
            if (push[i]) begin
                mem[wr_ptr] <= {ch_first[i], ch_last[i], ch_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end

        always_ff @(posedge ostream_clk or posedge ostream_rst) begin
            if (ostream_rst) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                in_pkt  <= 1'b0;
                full_q  <= 1'b0;
                empty_q <= 1'b1;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + AW'(1);
                if (pop[i])  rd_ptr <= rd_ptr + AW'(1);
                count   <= count_next;
                full_q  <= (count_next == CW'(FIFO_DEPTH));
                empty_q <= (count_next == '0);
                if (push[i]) begin
                    if (ch_last[i])       in_pkt <= 1'b0;
                    else if (ch_first[i]) in_pkt <= 1'b1;
                end
            end
        end
    end

    // Round-robin: nearest non-empty channel after ptr wins
    always_comb begin
        int d;
        int best;
        d       = 0;
        best    = NUM_CH;
        next_ch = ptr;
        any_req = |(~buff_empty);
        for (int i = 0; i < NUM_CH; i++) begin
            d = (i + NUM_CH - 1 - int'(ptr)) % NUM_CH;
            if (!buff_empty[i] && d < best) begin
                best    = d;
                next_ch = CH_W'(i);
            end
        end
    end

    assign head_sel = head[ptr];

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        load       = 1'b0;
        pop        = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = STREAM;
                    ptr_next   = next_ch;
                end
            end
            STREAM: begin
                if (!buff_empty[ptr] && (!ostream_valid || ostream_ready)) begin
                    load     = 1'b1;
                    pop[ptr] = 1'b1;
                    if (head_sel[DATA_WIDTH]) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ostream_clk or posedge ostream_rst) begin
        if (ostream_rst) begin
            state         <= IDLE;
            ptr           <= CH_W'(NUM_CH - 1);
            ostream_valid <= 1'b0;
            ostream_data  <= '0;
            ostream_first <= 1'b0;
            ostream_last  <= 1'b0;
            ostream_ch_id <= '0;
            proto_err     <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (|err_hit) proto_err <= 1'b1;
            if (load) begin
                ostream_valid <= 1'b1;
                ostream_data  <= head_sel[DATA_WIDTH-1:0];
                ostream_first <= head_sel[EW-1];
                ostream_last  <= head_sel[DATA_WIDTH];
                ostream_ch_id <= ptr;
            end else if (ostream_ready) begin
                ostream_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ostream_pkt_arbiter.sv
// tb/tb_ostream_pkt_arbiter.sv - directed and randomized bench with per-channel scoreboard
module tb_ostream_pkt_arbiter;
    localparam int DW    = 32;
    localparam int NCH   = 2;
    localparam int DEPTH = 8;
    localparam int CW    = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_first;
    logic [NCH-1:0]    ch_last;
    logic [NCH-1:0]    ch_ready;
    logic              ostream_valid;
    logic [DW-1:0]     ostream_data;
    logic              ostream_first;
    logic              ostream_last;
    logic [CW-1:0]     ostream_ch_id;
    logic              ostream_ready;
    logic [NCH-1:0]    buff_full;
    logic [NCH-1:0]    buff_empty;
    logic              proto_err;

    ostream_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
        .ostream_clk(clk), .ostream_rst(rst),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_first(ch_first), .ch_last(ch_last),
        .ch_ready(ch_ready),
        .ostream_valid(ostream_valid), .ostream_data(ostream_data),
        .ostream_first(ostream_first), .ostream_last(ostream_last),
        .ostream_ch_id(ostream_ch_id), .ostream_ready(ostream_ready),
        .buff_full(buff_full), .buff_empty(buff_empty), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic [DW-1:0] d, input logic f, input logic l);
        ch_valid[ch]           = 1'b1;
        ch_data[ch*DW +: DW]   = d;
        ch_first[ch]           = f;
        ch_last[ch]            = l;
    endtask

    task automatic idle_in();
        ch_valid = '0;
        ch_first = '0;
        ch_last  = '0;
    endtask

    // Scoreboard: words accepted per channel must leave in order, packets unbroken
    logic [DW+1:0] expq [NCH][$];
    int            out_cnt = 0;
    int            push_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_word;
    logic [CW-1:0] prev_id;
    logic          out_in_pkt = 1'b0;
    logic [CW-1:0] out_ch;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) expq[i].delete();
            prev_stall = 1'b0;
            out_in_pkt = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i] && ch_ready[i]) begin
                    expq[i].push_back({ch_first[i], ch_last[i], ch_data[i*DW +: DW]});
                    push_cnt++;
                end
            end
            if (prev_stall) begin
                chk("hold_valid", ostream_valid, 1'b1);
                chk("hold_word", {ostream_first, ostream_last, ostream_data}, prev_word);
                chk("hold_id", ostream_ch_id, prev_id);
            end
            if (ostream_valid && ostream_ready) begin
                out_cnt++;
                chk("sb_avail", expq[ostream_ch_id].size() > 0, 1'b1);
                if (expq[ostream_ch_id].size() > 0)
                    chk("sb_word", {ostream_first, ostream_last, ostream_data}, expq[ostream_ch_id].pop_front());
                if (out_in_pkt && !ostream_first) chk("atomic_ch", ostream_ch_id, out_ch);
                if (ostream_first) begin
                    out_ch     = ostream_ch_id;
                    out_in_pkt = !ostream_last;
                end else if (ostream_last) begin
                    out_in_pkt = 1'b0;
                end
            end
            prev_stall = ostream_valid && !ostream_ready;
            prev_word  = {ostream_first, ostream_last, ostream_data};
            prev_id    = ostream_ch_id;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int            guard;
    int            base_out;
    int            base_push;
    logic          pending;
    logic [NCH-1:0] acc;
    int            rem  [NCH];
    logic          have [NCH];
    logic [DW+1:0] cur  [NCH];

    task automatic gen_word(input int i);
        logic f;
        f = 1'b0;
        if (rem[i] == 0) begin
            rem[i] = $urandom_range(1, 5);
            f = 1'b1;
        end
        rem[i]--;
        cur[i]  = {f, rem[i] == 0, DW'($urandom)};
        have[i] = 1'b1;
    endtask

    task automatic apply_cur(input int i, input logic v);
        ch_valid[i]         = v;
        ch_first[i]         = cur[i][DW+1];
        ch_last[i]          = cur[i][DW];
        ch_data[i*DW +: DW] = cur[i][DW-1:0];
    endtask

    initial begin
        rst = 1'b1; ch_valid = '0; ch_data = '0; ch_first = '0; ch_last = '0; ostream_ready = 1'b0;
        for (int i = 0; i < NCH; i++) begin rem[i] = 0; have[i] = 1'b0; cur[i] = '0; end
        tick(); tick();
        chk("rst_valid", ostream_valid, 1'b0);
        chk("rst_data", ostream_data, '0);
        chk("rst_fl", {ostream_first, ostream_last}, 2'b00);
        chk("rst_id", ostream_ch_id, '0);
        chk("rst_err", proto_err, 1'b0);
        chk("rst_ready", ch_ready, 2'b00);
        chk("rst_empty", buff_empty, 2'b11);
        chk("rst_full", buff_full, 2'b00);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", ch_ready, 2'b11);

        // 1: single 4-word packet, latency and framing
        ostream_ready = 1'b1;
        drive(0, 32'hA0, 1, 0); tick();
        chk("s1_lat_k", ostream_valid, 1'b0);
        drive(0, 32'hA1, 0, 0); tick();
        chk("s1_lat_k1", ostream_valid, 1'b0);
        drive(0, 32'hA2, 0, 0); tick();
        chk("s1_lat_k2", ostream_valid, 1'b1);
        chk("s1_w0", {ostream_first, ostream_last, ostream_data}, {2'b10, 32'hA0});
        chk("s1_id", ostream_ch_id, 1'b0);
        drive(0, 32'hA3, 0, 1); tick();
        chk("s1_w1", {ostream_first, ostream_last, ostream_data}, {2'b00, 32'hA1});
        idle_in(); tick();
        chk("s1_w2", {ostream_first, ostream_last, ostream_data}, {2'b00, 32'hA2});
        tick();
        chk("s1_w3", {ostream_first, ostream_last, ostream_data}, {2'b01, 32'hA3});
        tick();
        chk("s1_end", ostream_valid, 1'b0);

        // 2: simultaneous packets, one bubble, round-robin
        rst = 1'b1; tick(); rst = 1'b0; tick();
        drive(0, 32'hB0, 1, 0); drive(1, 32'hC0, 1, 0); tick();
        drive(0, 32'hB1, 0, 0); drive(1, 32'hC1, 0, 1); tick();
        idle_in(); drive(0, 32'hB2, 0, 1); tick();
        chk("s2_b0", {ostream_valid, ostream_ch_id, ostream_data}, {2'b10, 32'hB0});
        idle_in(); tick();
        chk("s2_b1", {ostream_valid, ostream_ch_id, ostream_data}, {2'b10, 32'hB1});
        tick();
        chk("s2_b2", {ostream_valid, ostream_last, ostream_data}, {2'b11, 32'hB2});
        tick();
        chk("s2_bubble", ostream_valid, 1'b0);
        tick();
        chk("s2_c0", {ostream_valid, ostream_ch_id, ostream_first, ostream_data}, {3'b111, 32'hC0});
        tick();
        chk("s2_c1", {ostream_valid, ostream_ch_id, ostream_last, ostream_data}, {3'b111, 32'hC1});
        tick();
        chk("s2_idle", ostream_valid, 1'b0);
        drive(0, 32'hD0, 1, 1); drive(1, 32'hE0, 1, 1); tick();
        idle_in(); tick(); tick();
        chk("s2_rr0", {ostream_valid, ostream_ch_id, ostream_data}, {2'b10, 32'hD0});
        tick();
        chk("s2_rr_bubble", ostream_valid, 1'b0);
        tick();
        chk("s2_rr1", {ostream_valid, ostream_ch_id, ostream_data}, {2'b11, 32'hE0});
        tick();

        // 3: fill ch1 with downstream stalled
        ostream_ready = 1'b0;
        base_out = out_cnt;
        for (int n = 0; n < 9; n++) begin
            chk("s3_ready_fill", ch_ready[1], 1'b1);
            drive(1, 32'hF0 + n, n == 0, 1'b0); tick();
        end
        chk("s3_full", buff_full[1], 1'b1);
        chk("s3_not_ready", ch_ready[1], 1'b0);
        chk("s3_head_held", {ostream_valid, ostream_data}, {1'b1, 32'hF0});
        drive(1, 32'hF9, 0, 1);
        for (int n = 0; n < 2; n++) begin
            tick();
            chk("s3_refuse", ch_ready[1], 1'b0);
        end
        ostream_ready = 1'b1;
        guard = 0;
        while (!ch_ready[1] && guard < 20) begin tick(); guard++; end
        chk("s3_accept_to", guard < 20, 1'b1);
        tick(); idle_in();
        guard = 0;
        while ((!buff_empty[1] || ostream_valid) && guard < 40) begin tick(); guard++; end
        chk("s3_drain_to", guard < 40, 1'b1);
        chk("s3_empty", buff_empty[1], 1'b1);
        chk("s3_count", out_cnt - base_out, 10);

        // 4: ready toggling every cycle
        base_out = out_cnt;
        for (int n = 0; n < 6; n++) begin
            drive(0, DW'($urandom), n == 0, n == 5);
            ostream_ready = ~ostream_ready;
            tick();
        end
        idle_in();
        guard = 0;
        while ((out_cnt - base_out) < 6 && guard < 40) begin
            ostream_ready = ~ostream_ready; tick(); guard++;
        end
        ostream_ready = 1'b1; tick(); tick();
        chk("s4_count", out_cnt - base_out, 6);
        chk("s4_sb_empty", expq[0].size(), 0);

        // Randomized traffic on both channels with random backpressure
        base_out = out_cnt; base_push = push_cnt;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!have[i]) gen_word(i);
                apply_cur(i, $urandom_range(0, 3) != 0);
            end
            ostream_ready = $urandom_range(0, 3) != 0;
            acc = ch_valid & ch_ready;
            tick();
            for (int i = 0; i < NCH; i++) if (acc[i]) have[i] = 1'b0;
        end
        guard = 0; pending = 1'b1;
        while (pending && guard < 200) begin
            pending = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (!have[i] && rem[i] != 0) gen_word(i);
                apply_cur(i, have[i]);
                if (have[i]) pending = 1'b1;
            end
            ostream_ready = 1'b1;
            acc = ch_valid & ch_ready;
            tick();
            for (int i = 0; i < NCH; i++) if (acc[i]) have[i] = 1'b0;
            guard++;
        end
        chk("rnd_flush_to", pending, 1'b0);
        idle_in(); ostream_ready = 1'b1;
        guard = 0;
        while ((buff_empty != 2'b11 || ostream_valid) && guard < 100) begin tick(); guard++; end
        chk("rnd_drain_to", guard < 100, 1'b1);
        chk("rnd_count", out_cnt - base_out, push_cnt - base_push);
        chk("rnd_sb0", expq[0].size(), 0);
        chk("rnd_sb1", expq[1].size(), 0);
        chk("rnd_no_err", proto_err, 1'b0);

        // 5: framing error is sticky, words still delivered
        base_out = out_cnt;
        drive(0, 32'h50, 1, 0); tick();
        chk("s5_err_before", proto_err, 1'b0);
        drive(0, 32'h51, 1, 1); tick();
        chk("s5_err_set", proto_err, 1'b1);
        idle_in();
        for (int n = 0; n < 6; n++) tick();
        chk("s5_err_sticky", proto_err, 1'b1);
        chk("s5_count", out_cnt - base_out, 2);

        // 6: reset mid-packet
        drive(0, 32'h60, 1, 0); tick();
        drive(0, 32'h61, 0, 0); tick();
        drive(0, 32'h62, 0, 0); tick();
        drive(0, 32'h63, 0, 1); tick();
        chk("s6_mid", {ostream_valid, ostream_data}, {1'b1, 32'h61});
        rst = 1'b1; #1;
        chk("s6_valid", ostream_valid, 1'b0);
        chk("s6_word", {ostream_first, ostream_last, ostream_data, ostream_ch_id}, '0);
        chk("s6_err", proto_err, 1'b0);
        chk("s6_ready", ch_ready, 2'b00);
        chk("s6_flags", {buff_empty, buff_full}, 4'b1100);
        idle_in(); tick(); rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("s6_quiet", ostream_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
